instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 5 +
 rtl/instr_fetch.sv | 82 ++++++++
 2 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared datapath width and default reset PC for the fetch stage
package instr_fetch_pkg;
  localparam int REGWIDTH = 32;
  localparam logic [REGWIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetch/issue FSM with imem handshake, redirect, ack timeout and sticky faults
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [REGWIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump,
  input  logic [REGWIDTH-1:0] PCout,
  input  logic                stall,
  output logic                imem_req,
  output logic [REGWIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [REGWIDTH-1:0] imem_rdata,
  output logic [REGWIDTH-1:0] inst,
  output logic                inst_valid,
  output logic [REGWIDTH-1:0] PCin,
  output logic [REGWIDTH-1:0] pc_plus4,
  output logic [1:0]          fault
);
  typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1, FAULT = 2'd2} state_e;
  localparam int F_TIMEOUT = 0;
  localparam int F_MISALIGN = 1;
  state_e state_q, state_d;
  logic [REGWIDTH-1:0] pc_q, pc_d, inst_q, inst_d;
  logic [31:0] wait_q, wait_d;
  logic [1:0] fault_q, fault_d;
  logic take;
  assign take = (branch & zero) | jump;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    wait_d = wait_q;
    fault_d = fault_q;
    if (state_q == FETCH) begin
      if (imem_ack) begin
        inst_d = imem_rdata;
        state_d = ISSUE;
      end else if (wait_q + 32'd1 == ACK_TIMEOUT) begin
        fault_d[F_TIMEOUT] = 1'b1;
        state_d = FAULT;
      end else wait_d = wait_q + 32'd1;
    end else if (state_q == ISSUE && !stall) begin
      // a misaligned redirect keeps the issuing PC so the fault points at the culprit
      if (take && PCout[1:0] != 2'b00) begin
        fault_d[F_MISALIGN] = 1'b1;
        state_d = FAULT;
      end else begin
        pc_d = take ? PCout : pc_plus4;
        wait_d = '0;
        state_d = FETCH;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      inst_q <= '0;
      wait_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      wait_q <= wait_d;
      fault_q <= fault_d;
    end
  end
  assign imem_req = (state_q == FETCH) & ~rst;
  assign imem_addr = pc_q;
  assign inst = inst_q;
  assign inst_valid = state_q == ISSUE;
  assign PCin = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign fault = fault_q;
endmodule
